id_mem_arbiter: RTL and testbench

//  Shares the single-port player-ID memory (16-bit ID per internal slot) between NREQ readers:

---
 rtl/id_mem_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/id_mem_arbiter.sv | 103 ++++++++++
 tb/tb_id_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_mem_pkg.sv
// Shared definitions for the player-ID memory arbiter: FSM encoding, default widths
// and a constant clog2 helper used to size pointer/owner fields.
package id_mem_pkg;

    localparam int DEF_AW      = 5;
    localparam int DEF_DW      = 16;
    localparam int DEF_MEM_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr with wrap.
// Reusable for any shared resource in the game datapath.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   winner_idx,
    output logic            any
);

    logic found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = PW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/id_mem_arbiter.sv
// Round-robin arbiter for the single-port player-ID memory, one read in flight at a time.
// Handshake: req[i] is held until gnt[i] pulses; rdata is valid only in the one cycle rdata_valid[i] is high.
module id_mem_arbiter
    import id_mem_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]   gnt,
    output logic [DW-1:0]     rdata,
    output logic [NREQ-1:0]   rdata_valid,
    output logic              busy,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_dout,
    output state_t            fsm_state
);

    localparam int PW = clog2(NREQ);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [2:0]      cnt;
    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx;
    logic            any_req;
    logic [AW-1:0]   sel_addr;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req        (req),
        .ptr        (ptr),
        .winner     (win),
        .winner_idx (win_idx),
        .any        (any_req)
    );

    always_comb begin
        sel_addr = addr[0 +: AW];
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) sel_addr = addr[i*AW +: AW];
        end
    end

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            gnt         <= '0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            rdata       <= '0;
            rdata_valid <= '0;
            busy        <= 1'b0;
        end else begin
            gnt         <= '0;
            mem_rd      <= 1'b0;
            rdata_valid <= '0;
            case (state)
                ST_IDLE: begin
                    // Entered in the rdata_valid cycle, so busy only drops if nobody is waiting.
                    busy <= any_req;
                    if (any_req) begin
                        gnt      <= win;
                        mem_rd   <= 1'b1;
                        mem_addr <= sel_addr;
                        owner    <= win_idx;
                        ptr      <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= 3'(MEM_LAT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 3'd0) begin
                        rdata       <= mem_dout;
                        rdata_valid <= NREQ'(1) << owner;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_mem_arbiter.sv
// Bench for id_mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-timing model; a second instance covers the long-latency build.
module tb_id_mem_arbiter;
    import id_mem_pkg::*;

    localparam int NREQ  = 4;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int LAT   = 2;
    localparam int LAT_B = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req, gnt, rdata_valid;
    logic [NREQ*AW-1:0] addr;
    logic [DW-1:0]      rdata, mem_dout;
    logic               busy, mem_rd;
    logic [AW-1:0]      mem_addr;
    state_t             fsm_state;

    logic [NREQ-1:0]    req_b, gnt_b, rdata_valid_b;
    logic [NREQ*AW-1:0] addr_b;
    logic [DW-1:0]      rdata_b, mem_dout_b;
    logic               busy_b, mem_rd_b;
    logic [AW-1:0]      mem_addr_b;
    state_t             fsm_state_b;

    id_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt), .rdata(rdata),
        .rdata_valid(rdata_valid), .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .fsm_state(fsm_state)
    );

    id_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .addr(addr_b), .gnt(gnt_b), .rdata(rdata_b),
        .rdata_valid(rdata_valid_b), .busy(busy_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b),
        .mem_dout(mem_dout_b), .fsm_state(fsm_state_b)
    );

    // Memory models: data is driven only in the exact cycle MEM_LAT after mem_rd, X otherwise.
    logic [DW-1:0]    mem [32];
    logic [LAT-1:0]   pipe;
    logic [LAT_B-1:0] pipe_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe   <= '0;
            pipe_b <= '0;
        end else begin
            pipe   <= (pipe << 1) | LAT'(mem_rd);
            pipe_b <= (pipe_b << 1) | LAT_B'(mem_rd_b);
        end
    end

    assign mem_dout   = pipe[LAT-1]     ? mem[mem_addr]   : 'x;
    assign mem_dout_b = pipe_b[LAT_B-1] ? mem[mem_addr_b] : 'x;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: each access is a record of its grant cycle and its data-return cycle.
    int            cyc = 0;
    int            m_ptr, m_owner, m_gnt_cyc, m_val_cyc;
    bit            m_active;
    logic [DW-1:0] m_data, m_rdata;
    logic [AW-1:0] m_addr;

    task automatic step();
        logic [NREQ-1:0]    r_s;
        logic [NREQ*AW-1:0] a_s;
        logic               rst_s;
        logic [NREQ-1:0]    e_gnt, e_val;
        logic               e_busy;
        int                 w;
        r_s   = req;
        a_s   = addr;
        rst_s = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            m_active = 0;
            m_ptr    = 0;
            m_rdata  = '0;
            m_addr   = '0;
        end else begin
            if (m_active && cyc - 1 > m_val_cyc) m_active = 0;
            if ((!m_active || cyc - 1 == m_val_cyc) && r_s != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && r_s[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                m_active  = 1;
                m_owner   = w;
                m_gnt_cyc = cyc;
                m_val_cyc = cyc + LAT + 1;
                m_addr    = a_s[w*AW +: AW];
                m_data    = mem[m_addr];
                m_ptr     = (w + 1) % NREQ;
            end
        end
        e_gnt  = (m_active && m_gnt_cyc == cyc) ? NREQ'(1) << m_owner : '0;
        e_val  = (m_active && m_val_cyc == cyc) ? NREQ'(1) << m_owner : '0;
        if (e_val != '0) m_rdata = m_data;
        e_busy = m_active && cyc <= m_val_cyc;
        check("gnt", gnt, e_gnt);
        check("mem_rd", mem_rd, |e_gnt);
        check("mem_addr", mem_addr, m_addr);
        check("rdata_valid", rdata_valid, e_val);
        check("rdata", rdata, m_rdata);
        check("busy", busy, e_busy);
    endtask

    // kind 0 waits for a grant, kind 1 for a data return.
    task automatic wait_sig(input int kind, input int max_steps, input string tag);
        bit found;
        found = 0;
        for (int n = 0; n < max_steps && !found; n++) begin
            step();
            if ((kind == 0 && gnt != '0) || (kind == 1 && rdata_valid != '0)) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    int g_idx[5], g_cyc[5], v_idx[5];
    int ng, nv, g0, rd_cyc, v_cyc;
    bit f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        req    = '0;
        addr   = '0;
        req_b  = '0;
        addr_b = '0;
        for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
        mem[3] = 16'h1234;
        mem[7] = 16'h0909;

        // Reset state
        step();
        step();
        check("rst_fsm_state", fsm_state, ST_IDLE);
        rst = 1'b0;
        step();

        // Single request, exact cycle timing
        addr[0 +: AW] = 5'd3;
        req = 4'b0001;
        step();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_mem_rd", mem_rd, 1);
        check("t1_mem_addr", mem_addr, 3);
        check("t1_busy", busy, 1);
        req = '0;
        step();
        step();
        check("t1_no_early_valid", rdata_valid, 0);
        step();
        check("t1_valid", rdata_valid, 4'b0001);
        check("t1_rdata", rdata, 16'h1234);
        step();
        check("t1_valid_pulse", rdata_valid, 0);
        check("t1_busy_low", busy, 0);
        check("t1_rdata_hold", rdata, 16'h1234);

        // All four requesting: round-robin order and spacing
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = AW'(10 + i);
        req = '1;
        ng = 0;
        nv = 0;
        for (int k = 0; k < 5; k++) begin
            g_idx[k] = -1; g_cyc[k] = -1; v_idx[k] = -1;
        end
        for (int n = 0; n < 22; n++) begin
            step();
            if (gnt != '0 && ng < 5) begin
                g_idx[ng] = oh2i(gnt);
                g_cyc[ng] = cyc;
                ng++;
            end
            if (rdata_valid != '0 && nv < 5) begin
                v_idx[nv] = oh2i(rdata_valid);
                nv++;
            end
        end
        check("t2_num_gnt", ng, 5);
        check("t2_num_valid", nv, 5);
        for (int k = 0; k < 5; k++) begin
            check("t2_order", g_idx[k], k % NREQ);
            check("t2_valid_owner", v_idx[k], k % NREQ);
            if (k > 0) check("t2_spacing", g_cyc[k] - g_cyc[k-1], LAT + 2);
        end
        req = '0;
        for (int n = 0; n < 8; n++) step();

        // Request arriving during WAIT is served right after the data return
        req = 4'b0001;
        wait_sig(0, 10, "t3_wait_gnt0");
        check("t3_gnt0", gnt, 4'b0001);
        req = '0;
        step();
        req = 4'b0010;
        wait_sig(1, 10, "t3_wait_valid0");
        check("t3_valid0", rdata_valid, 4'b0001);
        step();
        check("t3_gnt1_next", gnt, 4'b0010);
        req = '0;
        g0 = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (gnt[0]) g0++;
        end
        check("t3_no_regrant0", g0, 0);

        // Dropping req after the grant does not cancel the access
        addr[2*AW +: AW] = 5'd7;
        req = 4'b0100;
        wait_sig(0, 10, "t4_wait_gnt2");
        check("t4_gnt2", gnt, 4'b0100);
        check("t4_mem_addr", mem_addr, 7);
        step();
        req = '0;
        wait_sig(1, 10, "t4_wait_valid");
        check("t4_valid", rdata_valid, 4'b0100);
        check("t4_rdata", rdata, 16'h0909);
        for (int n = 0; n < 3; n++) step();

        // Reset during WAIT aborts the access and returns ptr to 0
        req = 4'b0010;
        wait_sig(0, 10, "t5_wait_gnt");
        req = '0;
        step();
        step();
        check("t5_in_wait", fsm_state, ST_WAIT);
        rst = 1'b1;
        #1;
        check("t5_async_gnt", gnt, 0);
        check("t5_async_valid", rdata_valid, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_mem_rd", mem_rd, 0);
        check("t5_async_mem_addr", mem_addr, 0);
        check("t5_async_rdata", rdata, 0);
        check("t5_async_state", fsm_state, ST_IDLE);
        step();
        rst = 1'b0;
        nv = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            step();
            if (rdata_valid != '0) nv++;
        end
        check("t5_no_valid", nv, 0);
        req = '1;
        step();
        check("t5_gnt_idx0", gnt, 4'b0001);
        req = '0;
        for (int n = 0; n < 6; n++) step();

        // Randomized traffic against the model
        for (int n = 0; n < 700; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req[i] && !gnt[i])) req[i] = ($urandom_range(0, 2) == 0);
                addr[i*AW +: AW] = AW'($urandom);
            end
            rst = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 1'b0;
        req = '0;
        for (int n = 0; n < 8; n++) step();

        // Long-latency build: data returns MEM_LAT+1 cycles after mem_rd
        addr_b[0 +: AW] = 5'd5;
        req_b = 4'b0001;
        f = 0;
        rd_cyc = -1;
        for (int n = 0; n < 10 && !f; n++) begin
            step();
            if (mem_rd_b) begin
                f = 1;
                rd_cyc = cyc;
            end
        end
        check("t6_mem_rd_seen", 32'(f), 1);
        check("t6_mem_addr", mem_addr_b, 5);
        req_b = '0;
        f = 0;
        v_cyc = -1;
        for (int n = 0; n < 20 && !f; n++) begin
            step();
            if (rdata_valid_b != '0) begin
                f = 1;
                v_cyc = cyc;
            end
        end
        check("t6_valid_seen", 32'(f), 1);
        check("t6_latency", v_cyc - rd_cyc, LAT_B + 1);
        check("t6_owner", rdata_valid_b, 4'b0001);
        check("t6_rdata", rdata_b, mem[5]);
        step();
        check("t6_valid_pulse", rdata_valid_b, 0);
        check("t6_busy_low", busy_b, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
